// File: rtl/apple_timing_seq.sv
// ---------------------------------------------------------------------------
// apple_timing_seq
//
// Master timing sequencer for the Apple II gate-level model. Runs from the
// 14.318 MHz master clock. It divides 14M into machine cycles, builds PHI0,
// Q3 and the DRAM strobes, and drives the controls of the 74S195 video/timing
// shift register. The PHI0-high half of the last machine cycle of each scan
// line is stretched so that the colour reference phase stays locked.
//
// Ports:
//   CLK_14M    in   master 14M clock, rising edge active
//   RST        in   asynchronous active-high reset
//   SR_MODE    in   0 = parallel load every cycle, 1 = shift only
//   PHI0       out  CPU phase 0
//   Q3         out  2 MHz asymmetric strobe
//   RASn       out  DRAM row strobe, active low
//   AXn        out  address mux select, low = column address
//   CASn       out  DRAM column strobe, active low
//   SR_SH_LDn  out  74S195 SH/LDn, low = parallel load
//   SR_J       out  74S195 J input
//   SR_K       out  74S195 K input
//   LONG_CYC   out  high throughout the stretched machine cycle
//   CYC_CNT    out  machine-cycle index within the scan line
//   CYC_START  out  one-tick pulse on tick 0 of every machine cycle
// ---------------------------------------------------------------------------
module apple_timing_seq #(
    parameter int HALF_TICKS   = 7,
    parameter int LONG_EXTRA   = 2,
    parameter int CYC_PER_LINE = 65
) (
    input  logic       CLK_14M,
    input  logic       RST,
    input  logic       SR_MODE,
    output logic       PHI0,
    output logic       Q3,
    output logic       RASn,
    output logic       AXn,
    output logic       CASn,
    output logic       SR_SH_LDn,
    output logic       SR_J,
    output logic       SR_K,
    output logic       LONG_CYC,
    output logic [6:0] CYC_CNT,
    output logic       CYC_START
);

    // Sequencer state. The output registers below present the decode of
    // this state one tick later, so every output (including CYC_CNT) stays
    // mutually aligned.
    logic       phase;
    logic [3:0] h;
    logic [6:0] cyc;

    logic       is_long;
    logic [3:0] half_len;
    logic       half_end;

    // Only the PHI0-high half of the last cycle of the line is stretched.
    always_comb begin
        is_long  = (cyc == 7'(CYC_PER_LINE - 1));
        half_len = 4'(HALF_TICKS);
        if (phase && is_long) begin
            half_len = 4'(HALF_TICKS + LONG_EXTRA);
        end
        half_end = (h == half_len - 4'd1);
    end

    // Tick-in-half counter, phase toggle, and machine-cycle counter that
    // advances on the high-to-low PHI0 transition.
    always_ff @(posedge CLK_14M or posedge RST) begin
        if (RST) begin
            phase <= 1'b0;
            h     <= 4'd0;
            cyc   <= 7'd0;
        end else begin
            if (half_end) begin
                h     <= 4'd0;
                phase <= ~phase;
                if (phase) begin
                    if (is_long) begin
                        cyc <= 7'd0;
                    end else begin
                        cyc <= cyc + 7'd1;
                    end
                end
            end else begin
                h <= h + 4'd1;
            end
        end
    end

    // Registered output decode. The same threshold rules apply in both
    // halves, so in the stretched half the strobes simply stay asserted
    // through the extra ticks. CYC_START is held low in reset, so its first
    // pulse appears on the first edge after reset is released. The load
    // pulse lands on the final tick of the PHI0-high half, whatever its
    // length, and is suppressed in shift-only mode.
    always_ff @(posedge CLK_14M or posedge RST) begin
        if (RST) begin
            PHI0      <= 1'b0;
            Q3        <= 1'b1;
            RASn      <= 1'b1;
            AXn       <= 1'b1;
            CASn      <= 1'b1;
            SR_SH_LDn <= 1'b1;
            SR_J      <= 1'b0;
            SR_K      <= 1'b1;
            LONG_CYC  <= 1'b0;
            CYC_CNT   <= 7'd0;
            CYC_START <= 1'b0;
        end else begin
            PHI0      <= phase;
            Q3        <= (h < 4'd4);
            RASn      <= ~(h >= 4'd2);
            AXn       <= ~(h >= 4'd3);
            CASn      <= ~(h >= 4'd4);
            SR_SH_LDn <= ~(phase && half_end && !SR_MODE);
            SR_J      <= 1'b0;
            SR_K      <= 1'b1;
            LONG_CYC  <= is_long;
            CYC_CNT   <= cyc;
            CYC_START <= (!phase && (h == 4'd0));
        end
    end

endmodule
